// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Multicycle control sequencer for the 32-bit MIPS core.
//   It steps the shared datapath (one memory port, one ALU, IR, PC) through
//   the fetch, decode, execute, memory and writeback steps.
//   Supported instructions: add (R-type), addi, lw, sw, beq, bne, j.
//   Each memory access waits for mem_ack. If the ack does not arrive within
//   TIMEOUT_CYCLES request cycles, the FSM enters TRAP.
//
// Parameters
//   TIMEOUT_CYCLES  request cycles allowed per access before TRAP (>= 2)
//   CNT_W           wait-counter width, must hold TIMEOUT_CYCLES
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   opcode[5:0]      IR[31:26], stable from DECODE until the next FETCH
//   zero             ALU zero flag (branch decision)
//   mem_ack          memory access complete, sampled on clk
//   ir_write         load IR from memory read data
//   pc_write         load PC
//   pc_src[1:0]      00 ALU result, 01 ALUOut, 10 jump target
//   iord             memory address select: 0 PC, 1 ALUOut
//   mem_read         memory read request
//   mem_write        memory write request
//   reg_write        register file write enable
//   reg_dst          1 rd, 0 rt
//   mem_to_reg       1 MDR, 0 ALUOut
//   alu_src_a        0 PC, 1 rs
//   alu_src_b[1:0]   00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2
//   alu_op[1:0]      00 add, 01 sub, 10 funct field
//   mem_timeout      sticky flag, set when TRAP is entered through a timeout
//   illegal_op       sticky flag, set when TRAP is entered on an unlisted
//                    opcode (only when ILLEGAL_OP_TRAP_EN is defined)
//   state[3:0]       current state encoding (debug)
//
// Optional feature macro: ILLEGAL_OP_TRAP_EN
//   Defined:   an unlisted opcode in DECODE goes to TRAP and sets illegal_op.
//   Undefined: an unlisted opcode executes as a NOP (returns to FETCH).
// ---------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       mem_timeout,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic       illegal_op,
`endif
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_BOOT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;
  logic             is_req;
  logic             timeout_hit;
  logic             op_illegal;

  // The three states that hold a memory request share the wait counter.
  assign is_req      = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                       (state_reg == S_MEM_WR);
  // An ack in the limit cycle wins over the timeout.
  assign timeout_hit = is_req && !mem_ack && (cnt_reg == CNT_LIMIT);
  assign op_illegal  = (state_reg == S_DECODE) &&
                       !(opcode inside {OP_R, OP_ADDI, OP_LW, OP_SW,
                                        OP_BEQ, OP_BNE, OP_J});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_BOOT;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_reg <= 1'b0;
    end else if (op_illegal) begin
      illegal_reg <= 1'b1;
    end
  end

  assign illegal_op = illegal_reg;
`endif

  // Counter is zero in every non-request state, so entering any request
  // state starts counting from zero.
  always_comb begin
    cnt_next = '0;
    if (is_req && !mem_ack && !timeout_hit) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign timeout_next = timeout_reg | timeout_hit;

  always_comb begin
    state_next = state_reg;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;

    case (state_reg)
      S_BOOT: state_next = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR load and PC+4 update happen only in the cycle the ack arrives.
        ir_write  = mem_ack;
        pc_write  = mem_ack;
        if (mem_ack) begin
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R:          state_next = S_EXEC_R;
          OP_ADDI:       state_next = S_ADDI_EX;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_J:          state_next = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:       state_next = S_TRAP;
`else
          default:       state_next = S_FETCH;
`endif
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ack) begin
          state_next = S_MEM_WB;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ack) begin
          state_next = S_FETCH;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
        end
      end

      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = S_R_WB;
      end

      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = S_FETCH;
      end

      S_ADDI_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        // opcode is stable here: beq takes on zero, bne on not-zero.
        pc_write   = (opcode == OP_BNE) ? ~zero : zero;
        state_next = S_FETCH;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        state_next = S_FETCH;
      end

      S_TRAP: state_next = S_TRAP;

      default: state_next = S_BOOT;
    endcase
  end

  assign mem_timeout = timeout_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//   Testbench for mc_control_fsm.
//   Per-cycle vectors hold the inputs plus the expected state and outputs.
//   Expected values are pushed to a queue when a vector is driven. They are
//   popped and compared at the following falling edge.
//   Hand-written sequences cover the multi-cycle corner cases: memory
//   timeout, an ack in the limit cycle, and reset asserted mid-access.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  localparam int TO = 16;

  localparam int ST_BOOT = 0,  ST_FETCH = 1,   ST_DECODE = 2,  ST_MADDR = 3;
  localparam int ST_MRD  = 4,  ST_MWB   = 5,   ST_MWR    = 6,  ST_EXR   = 7;
  localparam int ST_RWB  = 8,  ST_AEX   = 9,   ST_AWB    = 10, ST_BR    = 11;
  localparam int ST_J    = 12, ST_TRAP  = 13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       ir_write, pc_write, iord, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, mem_timeout;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal_op;
`endif

  mc_control_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_timeout(mem_timeout),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        a;
    logic [3:0]  st;
    logic [15:0] o;
  } vec_t;

  vec_t        tbl[$];
  logic [19:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Expected per-state output patterns, as listed in the state table.
  logic [15:0] P_ZERO, P_FETCH, P_FETCH_ACK, P_DECODE, P_MADDR, P_MRD, P_MWB;
  logic [15:0] P_MWR, P_EXR, P_RWB, P_AWB, P_BR, P_BR_T, P_J, P_TRAP_TO;

  // Packs {ir_write, pc_write, pc_src, iord, mem_read, mem_write, reg_write,
  //        reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, mem_timeout}
  function automatic logic [15:0] mk(int ir, int pcw, int pcs, int io, int mr,
                                     int mw, int rw, int rd, int m2r, int asa,
                                     int asb, int aop, int to);
    return {ir[0], pcw[0], pcs[1:0], io[0], mr[0], mw[0], rw[0], rd[0],
            m2r[0], asa[0], asb[1:0], aop[1:0], to[0]};
  endfunction

  function automatic logic [19:0] actual();
    return {state, ir_write, pc_write, pc_src, iord, mem_read, mem_write,
            reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
            mem_timeout};
  endfunction

  task automatic add(input int op, input int z, input int a, input int st,
                     input logic [15:0] o);
    vec_t v;
    v.op = op[5:0]; v.z = z[0]; v.a = a[0]; v.st = st[3:0]; v.o = o;
    tbl.push_back(v);
  endtask

  task automatic check_now(input string name);
    logic [19:0] e, g;
    g = actual();
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, got state=%0d outs=%h", name,
               g[19:16], g[15:0]);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got state=%0d outs=%h, want state=%0d outs=%h",
                 name, g[19:16], g[15:0], e[19:16], e[15:0]);
      end else begin
        $display("ok   %s: state=%0d outs=%h", name, g[19:16], g[15:0]);
      end
    end
  endtask

  // Entered #1 after a rising edge; leaves #1 after the next rising edge.
  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      opcode  = tbl[i].op;
      zero    = tbl[i].z;
      mem_ack = tbl[i].a;
      exp_q.push_back({tbl[i].st, tbl[i].o});
      @(negedge clk);
      check_now($sformatf("%s[%0d]", name, i));
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    opcode  = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({4'd0, P_ZERO});
    @(negedge clk);
    check_now("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t want < 2ms", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    P_ZERO      = 16'h0;
    P_FETCH     = mk(0,0,0,0,1,0,0,0,0,0,1,0,0);
    P_FETCH_ACK = mk(1,1,0,0,1,0,0,0,0,0,1,0,0);
    P_DECODE    = mk(0,0,0,0,0,0,0,0,0,0,3,0,0);
    P_MADDR     = mk(0,0,0,0,0,0,0,0,0,1,2,0,0);
    P_MRD       = mk(0,0,0,1,1,0,0,0,0,0,0,0,0);
    P_MWB       = mk(0,0,0,0,0,0,1,0,1,0,0,0,0);
    P_MWR       = mk(0,0,0,1,0,1,0,0,0,0,0,0,0);
    P_EXR       = mk(0,0,0,0,0,0,0,0,0,1,0,2,0);
    P_RWB       = mk(0,0,0,0,0,0,1,1,0,0,0,0,0);
    P_AWB       = mk(0,0,0,0,0,0,1,0,0,0,0,0,0);
    P_BR        = mk(0,0,1,0,0,0,0,0,0,1,0,1,0);
    P_BR_T      = mk(0,1,1,0,0,0,0,0,0,1,0,1,0);
    P_J         = mk(0,1,2,0,0,0,0,0,0,0,0,0,0);
    P_TRAP_TO   = mk(0,0,0,0,0,0,0,0,0,0,0,0,1);

    // ---------------- main instruction table ----------------
    do_reset();
    // R-type, ack tied high: 1,2,7,8
    add(6'o00,0,1,ST_FETCH,P_FETCH_ACK); add(6'o00,0,1,ST_DECODE,P_DECODE);
    add(6'o00,0,1,ST_EXR,P_EXR);         add(6'o00,0,1,ST_RWB,P_RWB);
    // addi
    add('h08,0,1,ST_FETCH,P_FETCH_ACK);  add('h08,0,1,ST_DECODE,P_DECODE);
    add('h08,0,1,ST_AEX,P_MADDR);        add('h08,0,1,ST_AWB,P_AWB);
    // lw, one fetch wait, ack in 4th MEM_RD cycle, ack in MEM_WB ignored
    add('h23,0,0,ST_FETCH,P_FETCH);      add('h23,0,1,ST_FETCH,P_FETCH_ACK);
    add('h23,0,0,ST_DECODE,P_DECODE);    add('h23,0,0,ST_MADDR,P_MADDR);
    add('h23,0,0,ST_MRD,P_MRD);          add('h23,0,0,ST_MRD,P_MRD);
    add('h23,0,0,ST_MRD,P_MRD);          add('h23,0,1,ST_MRD,P_MRD);
    add('h23,0,1,ST_MWB,P_MWB);
    // sw
    add('h2b,0,1,ST_FETCH,P_FETCH_ACK);  add('h2b,0,1,ST_DECODE,P_DECODE);
    add('h2b,0,1,ST_MADDR,P_MADDR);      add('h2b,0,1,ST_MWR,P_MWR);
    // beq taken, bne not taken, bne taken, beq not taken
    add('h04,1,1,ST_FETCH,P_FETCH_ACK);  add('h04,1,1,ST_DECODE,P_DECODE);
    add('h04,1,1,ST_BR,P_BR_T);
    add('h05,1,1,ST_FETCH,P_FETCH_ACK);  add('h05,1,1,ST_DECODE,P_DECODE);
    add('h05,1,1,ST_BR,P_BR);
    add('h05,0,1,ST_FETCH,P_FETCH_ACK);  add('h05,0,1,ST_DECODE,P_DECODE);
    add('h05,0,1,ST_BR,P_BR_T);
    add('h04,0,1,ST_FETCH,P_FETCH_ACK);  add('h04,0,1,ST_DECODE,P_DECODE);
    add('h04,0,1,ST_BR,P_BR);
    // j
    add('h02,0,1,ST_FETCH,P_FETCH_ACK);  add('h02,0,1,ST_DECODE,P_DECODE);
    add('h02,0,1,ST_J,P_J);
    // illegal opcode
    add('h3f,0,1,ST_FETCH,P_FETCH_ACK);  add('h3f,0,0,ST_DECODE,P_DECODE);
`ifdef ILLEGAL_OP_TRAP_EN
    add('h3f,0,1,ST_TRAP,P_ZERO);        add('h00,0,1,ST_TRAP,P_ZERO);
`else
    add('h3f,0,0,ST_FETCH,P_FETCH);      add('h00,0,1,ST_FETCH,P_FETCH_ACK);
`endif
    run_tbl("instr");
`ifdef ILLEGAL_OP_TRAP_EN
    n_cmp++;
    if (illegal_op !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_op: got %b want 1", illegal_op);
    end else begin
      $display("ok   illegal_op: 1");
    end
`endif

    // ---------------- fetch timeout ----------------
    do_reset();
    for (int i = 0; i < TO; i++) add('h00,0,0,ST_FETCH,P_FETCH);
    add('h00,0,0,ST_TRAP,P_TRAP_TO);
    add('h00,0,1,ST_TRAP,P_TRAP_TO);
    add('h00,0,1,ST_TRAP,P_TRAP_TO);
    run_tbl("timeout");

    // ---------------- reset mid MEM_WR, then ack in limit cycle ----------
    do_reset();
    add('h2b,0,1,ST_FETCH,P_FETCH_ACK);  add('h2b,0,0,ST_DECODE,P_DECODE);
    add('h2b,0,0,ST_MADDR,P_MADDR);
    for (int i = 0; i < 10; i++) add('h2b,0,0,ST_MWR,P_MWR);
    run_tbl("sw_wait");
    // Still in MEM_WR: reset must drop the request without a clock edge.
    rst_n = 1'b0;
    #1;
    exp_q.push_back({4'd0, P_ZERO});
    check_now("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // The wait counter must restart from zero: 15 misses then ack on the 16th.
    for (int i = 0; i < TO - 1; i++) add('h00,0,0,ST_FETCH,P_FETCH);
    add('h00,0,1,ST_FETCH,P_FETCH_ACK);
    add('h00,0,0,ST_DECODE,P_DECODE);
    add('h00,0,0,ST_EXR,P_EXR);
    run_tbl("ack_limit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
